// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit: byte-lane placement, load extension, req/ack bus with timeout
module lsu_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic                  byte_op_i,
    input  logic                  load_unsigned_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [31:0]           wdata_i,
    output logic                  stall_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [31:0]           rdata_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    output logic [3:0]            mem_be_o,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_ack_i
);
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                r_state;
    state_t                w_next;
    logic                  r_write;
    logic                  r_byte;
    logic                  r_uns;
    logic [1:0]            r_lane;
    logic [7:0]            r_cnt;
    logic                  r_err;
    logic [31:0]           r_rdata;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic [3:0]            r_mem_be;
    logic                  w_misaligned;
    logic                  w_timeout;
    logic [7:0]            w_lane_byte;
    logic [31:0]           w_load_data;

    assign w_misaligned = ~byte_op_i & (addr_i[1:0] != 2'b00);
    assign w_timeout    = (r_cnt == TO_LAST);

    always_comb begin
        w_lane_byte = mem_rdata_i[7:0];
        case (r_lane)
            2'd1:    w_lane_byte = mem_rdata_i[15:8];
            2'd2:    w_lane_byte = mem_rdata_i[23:16];
            2'd3:    w_lane_byte = mem_rdata_i[31:24];
            default: w_lane_byte = mem_rdata_i[7:0];
        endcase
        w_load_data = mem_rdata_i;
        if (r_byte)
            w_load_data = {{24{~r_uns & w_lane_byte[7]}}, w_lane_byte};
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req_valid_i) w_next = w_misaligned ? S_RESP : S_ACCESS;
            S_ACCESS: if (mem_ack_i || w_timeout) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write     <= 1'b0;
            r_byte      <= 1'b0;
            r_uns       <= 1'b0;
            r_lane      <= 2'b00;
            r_cnt       <= 8'd0;
            r_err       <= 1'b0;
            r_rdata     <= 32'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_mem_be    <= 4'b0000;
        end else begin
            case (r_state)
                S_IDLE: if (req_valid_i) begin
                    r_write <= req_write_i;
                    r_byte  <= byte_op_i;
                    r_uns   <= load_unsigned_i;
                    r_lane  <= addr_i[1:0];
                    if (w_misaligned) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt       <= 8'd0;
                        r_mem_we    <= req_write_i;
                        r_mem_addr  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
                        r_mem_wdata <= byte_op_i ? {4{wdata_i[7:0]}} : wdata_i;
                        r_mem_be    <= byte_op_i ? (4'b0001 << addr_i[1:0]) : 4'b1111;
                    end
                end
                S_ACCESS: begin
                    // ack takes priority over a simultaneous timeout expiry
                    if (mem_ack_i) begin
                        r_err <= 1'b0;
                        if (!r_write) r_rdata <= w_load_data;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_rdata <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall_o     = rst_n & (((r_state == S_IDLE) & req_valid_i) | (r_state == S_ACCESS));
    assign done_o      = (r_state == S_RESP);
    assign err_o       = r_err;
    assign rdata_o     = r_rdata;
    assign mem_req_o   = (r_state == S_ACCESS);
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign mem_be_o    = r_mem_be;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - randomized self-checking bench for lsu_ctrl against a transaction-level model
module tb_lsu_ctrl;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_i, req_write_i, byte_op_i, load_unsigned_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, err_o;
    logic [31:0] rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ack_i;

    int n_checks = 0;
    int n_errs   = 0;
    logic [31:0] exp_rdata = 32'd0;

    lsu_ctrl #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid_i), .req_write_i(req_write_i), .byte_op_i(byte_op_i),
        .load_unsigned_i(load_unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete transaction; ack arrives on ACCESS cycle (dly+1), dly >= TO means never.
    task automatic do_op(input logic wr, input logic byt, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int dly, input logic [31:0] rd);
        int          lane, cycles;
        logic [31:0] b, e_be, e_wd, e_ld;
        logic        mis, e_err;
        lane = int'(addr % 4);
        mis  = !byt && lane != 0;
        e_be = byt ? (32'd1 << lane) : 32'hF;
        e_wd = byt ? (wd % 256) * 32'h01010101 : wd;
        b    = (rd >> (8 * lane)) % 256;
        e_ld = !byt ? rd : (!uns && b >= 128) ? b + 32'hFFFFFF00 : b;

        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = wr; byte_op_i = byt;
        load_unsigned_i = uns; addr_i = addr; wdata_i = wd;
        #1 check("stall_req", {31'd0, stall_o}, 32'd1);
        @(negedge clk);
        req_valid_i = 1'b0;
        if (mis) begin
            e_err = 1'b1;
        end else begin
            cycles = (dly < TO) ? dly + 1 : TO;
            for (int k = 0; k < cycles; k++) begin
                check("mem_req", {31'd0, mem_req_o}, 32'd1);
                check("stall_acc", {31'd0, stall_o}, 32'd1);
                check("done_acc", {31'd0, done_o}, 32'd0);
                check("mem_addr", mem_addr_o, addr - lane);
                check("mem_we", {31'd0, mem_we_o}, {31'd0, wr});
                check("mem_be", {28'd0, mem_be_o}, e_be);
                if (wr) check("mem_wdata", mem_wdata_o, e_wd);
                if (k == dly) begin
                    mem_ack_i = 1'b1; mem_rdata_i = rd;
                end
                @(negedge clk);
                mem_ack_i = 1'b0; mem_rdata_i = $urandom;
            end
            e_err = (dly >= TO);
            if (e_err) exp_rdata = 32'd0;
            else if (!wr) exp_rdata = e_ld;
        end
        check("done", {31'd0, done_o}, 32'd1);
        check("err", {31'd0, err_o}, {31'd0, e_err});
        check("rdata", rdata_o, exp_rdata);
        check("mem_req_resp", {31'd0, mem_req_o}, 32'd0);
        check("stall_resp", {31'd0, stall_o}, 32'd0);
        @(negedge clk);
        check("done_once", {31'd0, done_o}, 32'd0);
        check("err_hold", {31'd0, err_o}, {31'd0, e_err});
        check("rdata_hold", rdata_o, exp_rdata);
    endtask

    initial begin
        rst_n = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0; byte_op_i = 1'b0;
        load_unsigned_i = 1'b0; addr_i = 32'd0; wdata_i = 32'd0;
        mem_rdata_i = 32'd0; mem_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_outs", {stall_o, done_o, err_o, mem_req_o, mem_we_o, mem_be_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_addr", mem_addr_o, 32'd0);
        check("rst_wdata", mem_wdata_o, 32'd0);
        rst_n = 1'b1;

        do_op(1'b0, 1'b1, 1'b0, 32'h103, 32'd0, 0, 32'h80AA5511);
        check("lb_value", rdata_o, 32'hFFFFFF80);
        do_op(1'b0, 1'b1, 1'b1, 32'h103, 32'd0, 0, 32'h80AA5511);
        check("lbu_value", rdata_o, 32'h00000080);
        do_op(1'b1, 1'b1, 1'b0, 32'h202, 32'h123456C3, 3, 32'd0);
        do_op(1'b1, 1'b0, 1'b0, 32'h300, 32'hDEADBEEF, 0, 32'd0);
        check("sw_keeps_rdata", rdata_o, 32'h00000080);
        do_op(1'b0, 1'b0, 1'b0, 32'h105, 32'd0, 0, 32'd0);
        do_op(1'b0, 1'b0, 1'b0, 32'h104, 32'd0, TO, 32'h55555555);
        do_op(1'b0, 1'b0, 1'b0, 32'h108, 32'd0, TO - 1, 32'hCAFEF00D);
        check("late_ack_data", rdata_o, 32'hCAFEF00D);

        // reset asserted mid-transaction
        @(negedge clk);
        req_valid_i = 1'b1; req_write_i = 1'b0; byte_op_i = 1'b0; addr_i = 32'h500;
        @(negedge clk);
        req_valid_i = 1'b0;
        @(negedge clk);
        check("rst_mid_req", {31'd0, mem_req_o}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_outs", {29'd0, mem_req_o, stall_o, done_o}, 32'd0);
        check("rst_mid_rdata", rdata_o, 32'd0);
        exp_rdata = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        do_op(1'b0, 1'b0, 1'b0, 32'h600, 32'd0, 1, 32'h01234567);

        for (int i = 0; i < 60; i++) begin
            logic        wr, byt, uns;
            logic [31:0] a;
            int          d;
            wr = 1'($urandom); byt = 1'($urandom); uns = 1'($urandom);
            a = $urandom;
            if (!byt && ($urandom % 4) != 0) a = a & 32'hFFFFFFFC;
            d = (($urandom % 8) == 0) ? TO + int'($urandom % 3) : int'($urandom % 4);
            do_op(wr, byt, uns, a, $urandom, d, $urandom);
            mem_ack_i = 1'($urandom);
            @(negedge clk);
            check("stray_ack_done", {31'd0, done_o}, 32'd0);
            check("stray_ack_req", {31'd0, mem_req_o}, 32'd0);
            mem_ack_i = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
